fma_round_pack: RTL and testbench

Two-stage pipelined rounding and packing stage directly downstream of the FMA normalizer. Accepts the 27-bit normalized significand (24 significand bits plus guard, round and sticky) with its exponent and sign, applies IEEE-754 rounding, renormalizes on carry-out, detects overflow and underflow, and emits a packed single-precision result with exception flags. Valid/ready handshake on both sides, full throughput, no data loss under backpressure.

---
 rtl/fma_round_pack.sv | 168 ++++++++++++++++
 tb/tb_fma_round_pack.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fma_round_pack.sv
// rtl/fma_round_pack.sv - two-stage IEEE-754 single-precision round and pack (optional FMA_ROUND_MODES_EN)
module fma_round_pack #(
    parameter int SIG_WIDTH = 23,
    parameter int EXP_WIDTH = 8,
    parameter int BIAS      = 127
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [SIG_WIDTH+3:0]   in_sig,
    input  logic [EXP_WIDTH+1:0]   in_exp,
    input  logic                   in_zero,
    input  logic                   in_inf,
    input  logic                   in_nan,
    input  logic                   in_invalid,
    input  logic [1:0]             rnd_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SIG_WIDTH+EXP_WIDTH:0] result,
    output logic [3:0]             flags
);

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RDN = 2'b11;

    // Largest biased exponent code; reaching it means the value is no longer finite.
    localparam int EXP_MAX = 2 * BIAS + 1;

    localparam int RW = SIG_WIDTH + EXP_WIDTH + 1;

    // Pipeline control
    logic adv2;
    logic adv1;
    logic v1;

    assign adv2     = ~out_valid | out_ready;
    assign adv1     = ~v1 | adv2;
    assign in_ready = adv1;

    // Effective rounding mode: only honoured when the mode feature is built in.
    logic [1:0] rnd_eff;
`ifdef FMA_ROUND_MODES_EN
    assign rnd_eff = rnd_mode;
`else
    logic unused_rnd_mode;
    assign unused_rnd_mode = ^rnd_mode;
    assign rnd_eff = RM_RNE;
`endif

    // Stage 1 combinational rounding decision
    logic lsb, g, rs, inexact, inc;
    logic [SIG_WIDTH+1:0] sum_in;

    // Decide whether to increment the kept significand
    always_comb begin
        lsb     = in_sig[3];
        g       = in_sig[2];
        rs      = in_sig[1] | in_sig[0];
        inexact = g | rs;
        inc     = 1'b0;
        case (rnd_eff)
            RM_RNE:  inc = g & (rs | lsb);
            RM_RTZ:  inc = 1'b0;
            RM_RUP:  inc = ~in_sign & inexact;
            RM_RDN:  inc = in_sign & inexact;
            default: inc = 1'b0;
        endcase
        sum_in = {1'b0, in_sig[SIG_WIDTH+3:3]} + {{(SIG_WIDTH+1){1'b0}}, inc};
    end

    // Stage 1 registers
    logic                 s1_sign;
    logic [EXP_WIDTH+1:0] s1_exp;
    logic [SIG_WIDTH+1:0] s1_sum;
    logic                 s1_inexact;
    logic                 s1_zero, s1_inf, s1_nan, s1_invalid;
    logic [1:0]           s1_rnd;

    // Capture a rounded beat whenever stage 1 is free or draining
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1         <= 1'b0;
            s1_sign    <= 1'b0;
            s1_exp     <= '0;
            s1_sum     <= '0;
            s1_inexact <= 1'b0;
            s1_zero    <= 1'b0;
            s1_inf     <= 1'b0;
            s1_nan     <= 1'b0;
            s1_invalid <= 1'b0;
            s1_rnd     <= RM_RNE;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_sign    <= in_sign;
                s1_exp     <= in_exp;
                s1_sum     <= sum_in;
                s1_inexact <= inexact;
                s1_zero    <= in_zero;
                s1_inf     <= in_inf;
                s1_nan     <= in_nan;
                s1_invalid <= in_invalid;
                s1_rnd     <= rnd_eff;
            end
        end
    end

    // Stage 2 combinational renormalise, range check and pack
    logic signed [EXP_WIDTH+2:0] exp_adj;
    logic                        ovf, unf;
    logic [SIG_WIDTH-1:0]        frac;
    logic [RW-1:0]               inf_pat, max_pat, nxt_result;
    logic [3:0]                  nxt_flags;

    // Build the packed word and flags for the beat held in stage 1
    always_comb begin
        exp_adj = $signed({s1_exp[EXP_WIDTH+1], s1_exp})
                + $signed({{(EXP_WIDTH+2){1'b0}}, s1_sum[SIG_WIDTH+1]});
        frac    = s1_sum[SIG_WIDTH+1] ? '0 : s1_sum[SIG_WIDTH-1:0];
        ovf     = exp_adj >= EXP_MAX;
        unf     = exp_adj <= 0;
        inf_pat = {s1_sign, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
        max_pat = {s1_sign, {(EXP_WIDTH-1){1'b1}}, 1'b0, {SIG_WIDTH{1'b1}}};
        nxt_result = {s1_sign, exp_adj[EXP_WIDTH-1:0], frac};
        nxt_flags  = {3'b000, s1_inexact};
        if (s1_nan) begin
            nxt_result = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(SIG_WIDTH-1){1'b0}}};
            nxt_flags  = {s1_invalid, 3'b000};
        end else if (s1_inf) begin
            nxt_result = inf_pat;
            nxt_flags  = 4'b0000;
        end else if (s1_zero) begin
            nxt_result = {s1_sign, {(RW-1){1'b0}}};
            nxt_flags  = 4'b0000;
        end else if (ovf) begin
            nxt_flags = 4'b0101;
            case (s1_rnd)
                RM_RTZ:  nxt_result = max_pat;
                RM_RUP:  nxt_result = s1_sign ? max_pat : inf_pat;
                RM_RDN:  nxt_result = s1_sign ? inf_pat : max_pat;
                default: nxt_result = inf_pat;
            endcase
        end else if (unf) begin
            nxt_result = {s1_sign, {(RW-1){1'b0}}};
            nxt_flags  = 4'b0011;
        end
    end

    // Output register; holds result and flags while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= 4'b0000;
        end else if (adv2) begin
            out_valid <= v1;
            if (v1) begin
                result <= nxt_result;
                flags  <= nxt_flags;
            end
        end
    end

endmodule

// File: tb/tb_fma_round_pack.sv
// tb/tb_fma_round_pack.sv - scoreboard bench for fma_round_pack
module tb_fma_round_pack;

`ifdef FMA_ROUND_MODES_EN
    localparam bit MODES = 1'b1;
`else
    localparam bit MODES = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [26:0] in_sig;
    logic [9:0]  in_exp;
    logic        in_zero, in_inf, in_nan, in_invalid;
    logic [1:0]  rnd_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;
    logic [35:0] sb[$];

    fma_round_pack dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_sig     (in_sig),
        .in_exp     (in_exp),
        .in_zero    (in_zero),
        .in_inf     (in_inf),
        .in_nan     (in_nan),
        .in_invalid (in_invalid),
        .rnd_mode   (rnd_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flags      (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every accepted output beat is compared with the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got %h_%h with empty scoreboard", result, flags);
            end else begin
                logic [35:0] e;
                e = sb.pop_front();
                if ({result, flags} !== e) begin
                    errors++;
                    $display("FAIL beat: got result=%h flags=%b expected result=%h flags=%b",
                             result, flags, e[35:4], e[3:0]);
                end
            end
        end
    end

    // Present one beat and push its expectation when the transfer is certain
    task automatic send(input logic s, input logic [26:0] sig, input logic [9:0] e,
                        input logic [2:0] spec, input logic inv, input logic [1:0] rm,
                        input logic [31:0] er, input logic [3:0] ef);
        bit done;
        done       = 1'b0;
        in_valid   = 1'b1;
        in_sign    = s;
        in_sig     = sig;
        in_exp     = e;
        {in_nan, in_inf, in_zero} = spec;
        in_invalid = inv;
        rnd_mode   = rm;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back({er, ef});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats outstanding, expected 0", sb.size());
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_sig = '0; in_exp = '0;
        in_zero = 1'b0; in_inf = 1'b0; in_nan = 1'b0; in_invalid = 1'b0;
        rnd_mode = 2'b00; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("reset_state", {out_valid, in_ready, 2'b00, result}, {1'b0, 1'b1, 2'b00, 32'h0});
        check("reset_flags", {32'h0, flags}, 36'h0);
        @(posedge clk); #1;

        // Latency: one beat, out_valid on the second edge after presentation
        send(1'b0, 27'h4000000, 10'd127, 3'b000, 1'b0, 2'b00, 32'h3F800000, 4'b0000);
        check("lat_edge1", {35'h0, out_valid}, 36'h0);
        @(posedge clk); #1;
        check("lat_edge2", {35'h0, out_valid}, 36'h1);
        drain();

        // Rounding and renormalisation
        send(1'b0, 27'h7FFFFFC, 10'd127, 3'b000, 1'b0, 2'b00, 32'h40000000, 4'b0001);
        send(1'b0, 27'h400000C, 10'd127, 3'b000, 1'b0, 2'b00, 32'h3F800002, 4'b0001);
        send(1'b0, 27'h4000014, 10'd127, 3'b000, 1'b0, 2'b00, 32'h3F800002, 4'b0001);
        send(1'b1, 27'h4C00000, 10'd130, 3'b000, 1'b0, 2'b00, 32'hC1180000, 4'b0000);
        send(1'b0, 27'h4000001, 10'd127, 3'b000, 1'b0, 2'b10,
             MODES ? 32'h3F800001 : 32'h3F800000, 4'b0001);
        send(1'b1, 27'h4000001, 10'd127, 3'b000, 1'b0, 2'b11,
             MODES ? 32'hBF800001 : 32'hBF800000, 4'b0001);

        // Overflow
        send(1'b0, 27'h7FFFFFC, 10'd254, 3'b000, 1'b0, 2'b00, 32'h7F800000, 4'b0101);
        send(1'b0, 27'h7FFFFFC, 10'd254, 3'b000, 1'b0, 2'b01,
             MODES ? 32'h7F7FFFFF : 32'h7F800000, MODES ? 4'b0001 : 4'b0101);
        send(1'b0, 27'h4000004, 10'd255, 3'b000, 1'b0, 2'b01,
             MODES ? 32'h7F7FFFFF : 32'h7F800000, 4'b0101);
        send(1'b1, 27'h4000000, 10'd260, 3'b000, 1'b0, 2'b10,
             MODES ? 32'hFF7FFFFF : 32'hFF800000, 4'b0101);
        send(1'b0, 27'h4000000, 10'd300, 3'b000, 1'b0, 2'b11,
             MODES ? 32'h7F7FFFFF : 32'h7F800000, 4'b0101);

        // Underflow
        send(1'b0, 27'h4000004, 10'd0,   3'b000, 1'b0, 2'b00, 32'h00000000, 4'b0011);
        send(1'b1, 27'h4000000, 10'h3FD, 3'b000, 1'b0, 2'b00, 32'h80000000, 4'b0011);

        // Specials
        send(1'b1, 27'h4000000, 10'd127, 3'b010, 1'b0, 2'b01, 32'hFF800000, 4'b0000);
        send(1'b1, 27'h7FFFFFF, 10'd127, 3'b001, 1'b0, 2'b10, 32'h80000000, 4'b0000);
        send(1'b1, 27'h4000000, 10'd127, 3'b110, 1'b1, 2'b00, 32'h7FC00000, 4'b1000);
        send(1'b0, 27'h4000000, 10'd127, 3'b100, 1'b0, 2'b00, 32'h7FC00000, 4'b0000);
        drain();

        // Backpressure: 4 beats with a 3-cycle stall
        out_ready = 1'b0;
        send(1'b0, 27'h4000000, 10'd128, 3'b000, 1'b0, 2'b00, 32'h40000000, 4'b0000);
        send(1'b0, 27'h4000000, 10'd129, 3'b000, 1'b0, 2'b00, 32'h40800000, 4'b0000);
        check("stall_in_ready", {35'h0, in_ready}, 36'h0);
        check("stall_head", {result, flags}, {32'h40000000, 4'b0000});
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stall_hold", {out_valid, in_ready, 2'b00, result}, {1'b1, 1'b0, 2'b00, 32'h40000000});
        end
        out_ready = 1'b1;
        send(1'b0, 27'h4000000, 10'd130, 3'b000, 1'b0, 2'b00, 32'h41000000, 4'b0000);
        send(1'b1, 27'h4000000, 10'd131, 3'b000, 1'b0, 2'b00, 32'hC1800000, 4'b0000);
        drain();

        // Reset in the middle of a stall discards in-flight beats
        out_ready = 1'b0;
        send(1'b1, 27'h4000000, 10'd127, 3'b110, 1'b1, 2'b00, 32'h7FC00000, 4'b1000);
        send(1'b0, 27'h4000000, 10'd127, 3'b000, 1'b0, 2'b00, 32'h3F800000, 4'b0000);
        check("nan_held", {result, flags}, {32'h7FC00000, 4'b1000});
        #2 rst_n = 1'b0;
        #1;
        check("rst_async", {out_valid, 3'b000, result}, 36'h0);
        check("rst_flags", {32'h0, flags}, 36'h0);
        sb.delete();
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_in_ready", {35'h0, in_ready}, 36'h1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("rst_no_ghost", {35'h0, out_valid}, 36'h0);
        send(1'b0, 27'h4000000, 10'd127, 3'b000, 1'b0, 2'b00, 32'h3F800000, 4'b0000);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
